// File: rtl/pe_pkg.sv
// Shared types, limits and arithmetic helpers for the systolic processing element.
package pe_pkg;

    localparam int PE_MAX_MUL_LATENCY = 4;
    localparam int PE_MAX_ACC_WIDTH   = 64;

    typedef struct packed {
        logic valid;
        logic first;
        logic last;
    } pe_tag_t;

    // Signed: like-signed addends giving a result of the other sign. Unsigned: carry out.
    function automatic logic pe_add_ovf(input logic is_signed, input logic msb_a,
                                        input logic msb_b, input logic msb_sum,
                                        input logic carry);
        if (is_signed)
            return (msb_a == msb_b) && (msb_sum != msb_a);
        return carry;
    endfunction

    function automatic logic [PE_MAX_ACC_WIDTH-1:0] pe_sat_max(input int acc_width,
                                                               input bit is_signed);
        if (is_signed)
            return {PE_MAX_ACC_WIDTH{1'b1}} >> (PE_MAX_ACC_WIDTH + 1 - acc_width);
        return {PE_MAX_ACC_WIDTH{1'b1}} >> (PE_MAX_ACC_WIDTH - acc_width);
    endfunction

    function automatic logic [PE_MAX_ACC_WIDTH-1:0] pe_sat_min(input int acc_width,
                                                               input bit is_signed);
        if (is_signed)
            return {{(PE_MAX_ACC_WIDTH-1){1'b0}}, 1'b1} << (acc_width - 1);
        return '0;
    endfunction

endpackage

// File: rtl/pe_mul_pipe.sv
// Product pipeline with valid/first/last side-band; kept separate so a Booth or DSP
// multiplier can be dropped in without touching the accumulator.
module pe_mul_pipe
    import pe_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int MUL_LATENCY = 2,
    parameter int SIGNED      = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   a,
    input  logic [DATA_WIDTH-1:0]   b,
    input  pe_tag_t                 tag_in,
    output logic [2*DATA_WIDTH-1:0] prod,
    output pe_tag_t                 tag_out
);

    localparam int PW  = 2 * DATA_WIDTH;
    localparam int LAT = (MUL_LATENCY > PE_MAX_MUL_LATENCY) ? PE_MAX_MUL_LATENCY :
                         (MUL_LATENCY < 1) ? 1 : MUL_LATENCY;

    logic [PW-1:0] a_ext;
    logic [PW-1:0] b_ext;
    logic [PW-1:0] prod_d;
    logic [PW-1:0] prod_q [LAT];
    pe_tag_t       tag_q  [LAT];

    // Low 2*DW bits of the extended product are correct for both signed and unsigned.
    always_comb begin
        a_ext  = {{DATA_WIDTH{(SIGNED != 0) && a[DATA_WIDTH-1]}}, a};
        b_ext  = {{DATA_WIDTH{(SIGNED != 0) && b[DATA_WIDTH-1]}}, b};
        prod_d = a_ext * b_ext;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < LAT; i++) begin
                prod_q[i] <= '0;
                tag_q[i]  <= '0;
            end
        end else begin
            prod_q[0] <= prod_d;
            tag_q[0]  <= '{valid: tag_in.valid,
                           first: tag_in.valid & tag_in.first,
                           last:  tag_in.valid & tag_in.last};
            for (int i = 1; i < LAT; i++) begin
                prod_q[i] <= prod_q[i-1];
                tag_q[i]  <= tag_q[i-1];
            end
        end
    end

    assign prod    = prod_q[LAT-1];
    assign tag_out = tag_q[LAT-1];

endmodule

// File: rtl/systolic_pe_mac.sv
// Systolic-array PE: forwards operands east/south and accumulates one dot-product
// tile per first..last sequence, reporting the sum with a single-cycle pulse.
module systolic_pe_mac
    import pe_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int ACC_WIDTH   = 24,
    parameter int MUL_LATENCY = 2,
    parameter int SIGNED      = 1,
    parameter int SATURATE    = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] a_in,
    input  logic [DATA_WIDTH-1:0] b_in,
    input  logic                  valid_in,
    input  logic                  first_in,
    input  logic                  last_in,
    output logic [DATA_WIDTH-1:0] a_out,
    output logic [DATA_WIDTH-1:0] b_out,
    output logic                  valid_out,
    output logic                  first_out,
    output logic                  last_out,
    output logic [ACC_WIDTH-1:0]  result,
    output logic                  result_valid,
    output logic                  overflow
);

    localparam int PW  = 2 * DATA_WIDTH;
    localparam int MSB = ACC_WIDTH - 1;
    localparam logic [PE_MAX_ACC_WIDTH-1:0] SAT_MAX_W = pe_sat_max(ACC_WIDTH, SIGNED != 0);
    localparam logic [PE_MAX_ACC_WIDTH-1:0] SAT_MIN_W = pe_sat_min(ACC_WIDTH, SIGNED != 0);
    localparam logic [ACC_WIDTH-1:0]        SAT_MAX   = SAT_MAX_W[ACC_WIDTH-1:0];
    localparam logic [ACC_WIDTH-1:0]        SAT_MIN   = SAT_MIN_W[ACC_WIDTH-1:0];

    pe_tag_t             tag_in;
    pe_tag_t             tag_p;
    logic [PW-1:0]       prod;
    logic [ACC_WIDTH-1:0] acc_q;
    logic                ovf_q;
    logic [ACC_WIDTH-1:0] p_ext;
    logic [ACC_WIDTH:0]   sum_full;
    logic [ACC_WIDTH-1:0] sum_sat;
    logic [ACC_WIDTH-1:0] acc_next;
    logic                add_ovf;
    logic                ovf_next;

    assign tag_in = '{valid: valid_in, first: first_in, last: last_in};

    pe_mul_pipe #(
        .DATA_WIDTH  (DATA_WIDTH),
        .MUL_LATENCY (MUL_LATENCY),
        .SIGNED      (SIGNED)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .a       (a_in),
        .b       (b_in),
        .tag_in  (tag_in),
        .prod    (prod),
        .tag_out (tag_p)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_out     <= '0;
            b_out     <= '0;
            valid_out <= 1'b0;
            first_out <= 1'b0;
            last_out  <= 1'b0;
        end else begin
            a_out     <= a_in;
            b_out     <= b_in;
            valid_out <= valid_in;
            first_out <= first_in;
            last_out  <= last_in;
        end
    end

    always_comb begin
        p_ext          = {ACC_WIDTH{(SIGNED != 0) && prod[PW-1]}};
        p_ext[PW-1:0]  = prod;
        sum_full       = {1'b0, acc_q} + {1'b0, p_ext};
        add_ovf        = pe_add_ovf(SIGNED != 0, acc_q[MSB], p_ext[MSB],
                                    sum_full[MSB], sum_full[ACC_WIDTH]);
        sum_sat        = sum_full[ACC_WIDTH-1:0];
        // A signed overflow can only go negative-past-min when both addends were negative.
        if (add_ovf && (SATURATE != 0))
            sum_sat = ((SIGNED != 0) && acc_q[MSB]) ? SAT_MIN : SAT_MAX;
        if (tag_p.first) begin
            acc_next = p_ext;
            ovf_next = 1'b0;
        end else begin
            acc_next = sum_sat;
            ovf_next = ovf_q | add_ovf;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q        <= '0;
            ovf_q        <= 1'b0;
            result       <= '0;
            overflow     <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            if (tag_p.valid) begin
                if (tag_p.last) begin
                    result       <= acc_next;
                    overflow     <= ovf_next;
                    result_valid <= 1'b1;
                    acc_q        <= '0;
                    ovf_q        <= 1'b0;
                end else begin
                    acc_q <= acc_next;
                    ovf_q <= ovf_next;
                end
            end
        end
    end

endmodule
